// File: rtl/adder_arb_pkg.sv
// Shared types, defaults and helpers for the shared-adder arbiter.
package adder_arb_pkg;

  localparam int unsigned DEF_WIDTH   = 12;
  localparam int unsigned DEF_NUM_REQ = 4;
  // Widest operand the interleave helper supports; callers narrow the result.
  localparam int unsigned MAX_W       = 32;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Requester ID width; at least one bit even for two requesters.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Adder bus layout: bit 2k carries a[k], bit 2k+1 carries b[k].
  function automatic logic [2*MAX_W-1:0] interleave(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b);
    logic [2*MAX_W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(MAX_W); k++) begin
      r[2*k]   = a[k];
      r[2*k+1] = b[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
import adder_arb_pkg::*;

module rr_arbiter #(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  logic [ID_W-1:0] idx_c;

  // Wrapped search from the pointer; only the first hit is granted.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx_c       = '0;
    if (en) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx_c = ID_W'((32'(ptr) + off) % NUM_REQ);
        if (!grant_valid && req[idx_c]) begin
          grant_valid  = 1'b1;
          grant[idx_c] = 1'b1;
          grant_idx    = idx_c;
        end
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external combinational adder among NUM_REQ requesters with a
// round-robin grant and a one-entry tagged response register.
// Optional build macro: ADDER_SHARE_CHECK_EN adds a sticky adder self-check.
import adder_arb_pkg::*;

module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [2*WIDTH-1:0]       adder_in,
  input  logic [WIDTH:0]           adder_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum,
  output logic                     adder_err
);

  localparam int unsigned BUS_W = 2 * WIDTH;

  rsp_state_e          state, state_d;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     ptr_next_c;
  logic                can_issue_c;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic [WIDTH-1:0]    win_a, win_b;

  // A new result may be accepted when the slot is empty or is draining now.
  assign can_issue_c = (state == RSP_EMPTY) || rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (ptr),
    .en          (can_issue_c && !rst),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign rsp_valid = (state == RSP_FULL);

  // Winner operand select; zero when nobody is granted.
  always_comb begin
    win_a = '0;
    win_b = '0;
    if (grant_valid) begin
      win_a = req_a[grant_idx*WIDTH +: WIDTH];
      win_b = req_b[grant_idx*WIDTH +: WIDTH];
    end
  end

  assign adder_in = BUS_W'(interleave(MAX_W'(win_a), MAX_W'(win_b)));

  // Pointer moves just past the winner, wrapping at the last requester.
  assign ptr_next_c = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Response slot next-state.
  always_comb begin
    state_d = state;
    case (state)
      RSP_EMPTY: if (grant_valid) state_d = RSP_FULL;
      RSP_FULL: begin
        if (rsp_ready) state_d = grant_valid ? RSP_FULL : RSP_EMPTY;
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  // State, pointer and response payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RSP_EMPTY;
      ptr     <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
    end else begin
      state <= state_d;
      if (grant_valid) begin
        rsp_sum <= adder_out;
        rsp_id  <= grant_idx;
        ptr     <= ptr_next_c;
      end
    end
  end

`ifdef ADDER_SHARE_CHECK_EN
  logic [WIDTH:0] ref_sum_c;
  logic           err_q;

  assign ref_sum_c = {1'b0, win_a} + {1'b0, win_b};

  // Sticky flag set when the shared adder disagrees with the reference sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (grant_valid && (ref_sum_c != adder_out)) begin
      err_q <= 1'b1;
    end
  end

  assign adder_err = err_q;
`else
  assign adder_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed scoreboard bench for adder_share_arbiter (4 requesters, 12-bit).
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a, req_b;
  logic [23:0] adder_in;
  logic [12:0] adder_out;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [12:0] rsp_sum;
  logic        adder_err;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [12:0] sum;
  } exp_t;
  exp_t exp_q[$];

  adder_share_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .adder_in  (adder_in),
    .adder_out (adder_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .adder_err (adder_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder model, with an optional stuck-at-0 on result bit 3.
  logic [11:0] ma, mb;
  always_comb begin
    ma = '0;
    mb = '0;
    for (int k = 0; k < 12; k++) begin
      ma[k] = adder_in[2*k];
      mb[k] = adder_in[2*k+1];
    end
    adder_out = {1'b0, ma} + {1'b0, mb};
    if (fault) adder_out[3] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic [11:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  // Monitor: every accepted response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_sum), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      end
    end
  end

  // One cycle: drive, check grant at negedge, push expected on a grant.
  task automatic step(input logic r, input logic [3:0] vld, input logic [47:0] a,
                      input logic [47:0] b, input logic rr, input logic [3:0] exp_rdy,
                      input logic [1:0] exp_id, input logic [12:0] exp_sum);
    rst       = r;
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy == 4'b0000) check("adder_in_idle", 32'(adder_in), 32'h0);
    else exp_q.push_back('{id: exp_id, sum: exp_sum});
    @(posedge clk);
    #1;
  endtask

  logic [47:0] rr_a, rr_b;

  initial begin
    fault     = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rr_a = pk(12'h001, 12'h800, 12'hABC, 12'hFFF);
    rr_b = pk(12'h002, 12'h800, 12'h123, 12'hFFF);

    // Reset: no grants even with all requesters valid.
    step(1'b1, 4'b1111, rr_a, rr_b, 1'b1, 4'b0000, 2'd0, 13'h0);
    step(1'b1, 4'b1111, rr_a, rr_b, 1'b1, 4'b0000, 2'd0, 13'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
    check("reset_adder_err", 32'(adder_err), 32'h0);

    // Single request from requester 0.
    step(1'b0, 4'b0001, pk(12'h123, 0, 0, 0), pk(12'h456, 0, 0, 0), 1'b1, 4'b0001, 2'd0, 13'h0579);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
    check("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Carry-out from requester 2; pointer moves to 3.
    step(1'b0, 4'b0100, pk(0, 0, 12'hFFF, 0), pk(0, 0, 12'h001, 0), 1'b1, 4'b0100, 2'd2, 13'h1000);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
    // Requester 3 wraps the pointer back to 0.
    step(1'b0, 4'b1000, pk(0, 0, 0, 12'h7FF), pk(0, 0, 0, 12'h001), 1'b1, 4'b1000, 2'd3, 13'h0800);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);

    // Round-robin with all four held valid: 0,1,2,3,0,1.
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b0001, 2'd0, 13'h0003);
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b0010, 2'd1, 13'h1000);
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b0100, 2'd2, 13'h0BDF);
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b1000, 2'd3, 13'h1FFE);
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b0001, 2'd0, 13'h0003);
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b0010, 2'd1, 13'h1000);

    // Back-pressure for three cycles: response held, no grants.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, rr_a, rr_b, 1'b0, 4'b0000, 2'd0, 13'h0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
      check("stall_rsp_id", 32'(rsp_id), 32'h1);
      check("stall_rsp_sum", 32'(rsp_sum), 32'h1000);
    end
    // Drain and issue in the same cycle; pointer was frozen at 2.
    step(1'b0, 4'b1111, rr_a, rr_b, 1'b1, 4'b0100, 2'd2, 13'h0BDF);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);

    // Reset mid-flight: pointer is 3, requesters 1 and 2 pending.
    step(1'b0, 4'b0110, rr_a, rr_b, 1'b1, 4'b0010, 2'd1, 13'h1000);
    step(1'b1, 4'b0110, rr_a, rr_b, 1'b0, 4'b0000, 2'd0, 13'h0);
    exp_q.delete();
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_sum", 32'(rsp_sum), 32'h0);
    // Pointer back at 0: requester 0 wins over 1.
    step(1'b0, 4'b0011, rr_a, rr_b, 1'b1, 4'b0001, 2'd0, 13'h0003);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);

`ifdef ADDER_SHARE_CHECK_EN
    // Faulty adder drops bit 3 of 0x008 + 0.
    fault = 1'b1;
    check("err_before", 32'(adder_err), 32'h0);
    step(1'b0, 4'b0001, pk(12'h008, 0, 0, 0), '0, 1'b1, 4'b0001, 2'd0, 13'h0000);
    check("err_set", 32'(adder_err), 32'h1);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
    check("err_sticky", 32'(adder_err), 32'h1);
    fault = 1'b0;
    step(1'b1, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
    check("err_cleared", 32'(adder_err), 32'h0);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
`else
    check("err_tied_low", 32'(adder_err), 32'h0);
`endif

    step(1'b0, 4'b0000, '0, '0, 1'b1, 4'b0000, 2'd0, 13'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
